pixel_capture_dma: RTL
======================

// Module: pixel_capture_dma
// PURPOSE
//  Parametrised successor of the camera pixel buffer. Captures one frame from a
//  parallel VSYNC/HREF/DATA sensor bus, packs PIX_W-bit pixels into WORD_W-bit words
//  and writes them to the single-port frame SRAM through the s0_* port. Adds
//  re-arming, word-count reporting and overflow detection.
//  Sits between the sensor pads and the SRAM arbiter; the host CPU starts a capture
//  and later reads the SRAM.
// PARAMETERS
//  PIX_W      8             pixel/DATA width in bits
//  WORD_W     32            SRAM word width; must be an integer multiple of PIX_W
//  ADDR_W     18            SRAM address width
//  MAX_WORDS  153600        frame capacity in words (0x25800); 1 <= MAX_WORDS <= 2**ADDR_W
//  FILL_WORD  32'hA5A5A5A5  clear pattern, WORD_W bits (PIXCAP_SRAM_CLEAR_EN only)
// PORTS
//  clk        in   1        system clock
//  reset_n    in   1        asynchronous active-low reset
//  fetch_kick in   1        capture request, level, asynchronous to clk
//  fetch_done out  1        frame captured; held until fetch_kick is low
//  busy       out  1        high in CLEAR, ARM and RUN
//  VSYNC      in   1        sensor frame sync, rising edge = frame start
//  HREF       in   1        sensor line valid
//  DATA       in   PIX_W    sensor pixel data
//  s0_WE      out  1        SRAM write enable, active-low
//  s0_Addr    out  ADDR_W   SRAM word address
//  s0_WD      out  WORD_W   SRAM write data
//  last_addr  out  ADDR_W   address of the last word written in the frame
//  word_cnt   out  ADDR_W+1 words written in the last completed frame
//  overflow   out  1        sticky: the frame exceeded MAX_WORDS
// BEHAVIOUR
//  - Reset values: fetch_done=0, busy=0, s0_WE=1, s0_Addr=all-ones, s0_WD=0,
//    last_addr=0, word_cnt=0, overflow=0. Internal state = IDLE.
//  - Input sync:
//    - HREF and DATA pass through 2 retiming flops.
//    - VSYNC passes through 1 flop; its rising edge gives a 1-cycle frame_start.
//    - fetch_kick passes through a 2-flop synchroniser, giving kick_s.
//  - PPW = WORD_W/PIX_W. The pixel counter is modulo PPW and is cleared on
//    frame_start in ARM/RUN. It advances on every retimed HREF cycle and continues
//    across lines.
//  - Packing is LSB-first: the first pixel lands in s0_WD[PIX_W-1:0] and the last
//    pixel in the MSBs. The word is complete on the cycle the counter equals PPW-1
//    with HREF high.
//  - FSM:
//    - IDLE:  kick_s=1 -> CLEAR (with macro) or ARM (without). busy=1; overflow is
//      cleared on entry.
//    - CLEAR: see CONFIGURATION. -> ARM when done.
//    - ARM:   waits for frame_start -> RUN. Next address = 0.
//    - RUN:
//      - On a completed word: s0_WE=0 for exactly 1 cycle, s0_WD=packed word,
//        s0_Addr=next address. The next address then increments.
//      - When the next address reaches MAX_WORDS, further words rewrite address
//        MAX_WORDS-1 and set overflow=1.
//      - frame_start -> DONE, with last_addr=s0_Addr, word_cnt=words written
//        (saturates at MAX_WORDS) and fetch_done=1.
//      - A partial word pending at frame_start is discarded.
//    - DONE: busy=0. When kick_s=0: fetch_done<=0 -> IDLE (re-arm for a new kick).
//  - Latency: sensor pixel to SRAM write strobe = 3 clk after the last pixel of the
//    word is sampled at the pad.
//  - Simultaneous events:
//    - frame_start and a completed word in the same cycle: the write happens and is
//      counted, then DONE.
//    - kick_s dropping in ARM/RUN does not abort; the frame completes.
//  - Reset mid-operation forces reset values within the same cycle (async). A
//    partial SRAM write is not recovered.
//  - s0_WE is high in all states except the write cycles.
// CONFIGURATION
//  PIXCAP_SRAM_CLEAR_EN defined:
//  - IDLE->CLEAR writes FILL_WORD to addresses 0..2**ADDR_W-1, one per clk, with
//    s0_WE=0 (2**ADDR_W cycles).
//  - After the last address: s0_WE=1, -> ARM. frame_start during CLEAR is ignored.
//  PIXCAP_SRAM_CLEAR_EN undefined:
//  - No CLEAR state. IDLE -> ARM directly and SRAM contents are untouched.
// TESTING
//  1. Default parameters, kick=1, one frame of 4 lines x 8 px (DATA=00..1F):
//     8 writes, addr 0..7; word0=32'h03020100; word_cnt=8; last_addr=7;
//     fetch_done=1.
//  2. PIX_W=16, WORD_W=32, line of 4 px 1111,2222,3333,4444:
//     words 32'h22221111, 32'h44443333.
//  3. MAX_WORDS=4, a frame of 24 px (6 words): addr 0,1,2,3,3,3; overflow=1;
//     word_cnt=4.
//  4. A frame ending with 3 leftover px: no write for them; next frame counter
//     restarts at word boundary.
//  5. After DONE, drop kick, re-kick: fetch_done falls, second frame writes from
//     addr 0; overflow cleared.
//  6. With PIXCAP_SRAM_CLEAR_EN and ADDR_W=4: 16 writes of A5A5A5A5 before ARM.
//     Separately, assert reset_n=0 mid-RUN: all outputs return to reset values
//     immediately.

Source files
------------

// File: rtl/pixel_capture_dma.sv
// pixel_capture_dma
//   Captures one frame from a VSYNC/HREF/DATA sensor bus, packs PIX_W-bit pixels
//   LSB-first into WORD_W-bit words and writes them to a single-port SRAM.
//   Reports the word count and the last written address, and flags overflow
//   beyond MAX_WORDS.
//   Optional feature macro: PIXCAP_SRAM_CLEAR_EN. When defined, the whole SRAM
//   is filled with FILL_WORD before arming for a frame.
module pixel_capture_dma #(
  parameter int                 PIX_W     = 8,
  parameter int                 WORD_W    = 32,
  parameter int                 ADDR_W    = 18,
  parameter int                 MAX_WORDS = 153600,
  parameter logic [WORD_W-1:0]  FILL_WORD = WORD_W'(32'hA5A5A5A5)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_kick,
  output logic              fetch_done,
  output logic              busy,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [PIX_W-1:0]  DATA,
  output logic              s0_WE,
  output logic [ADDR_W-1:0] s0_Addr,
  output logic [WORD_W-1:0] s0_WD,
  output logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W:0]   word_cnt,
  output logic              overflow
);

  localparam int PPW   = WORD_W / PIX_W;
  localparam int CNT_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PPW - 1);
  localparam logic [ADDR_W:0]   MAX_CNT  = (ADDR_W + 1)'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] SAT_ADDR = ADDR_W'(MAX_WORDS - 1);

  localparam logic [2:0] IDLE  = 3'd0;
`ifdef PIXCAP_SRAM_CLEAR_EN
  localparam logic [2:0] CLEAR = 3'd1;
`endif
  localparam logic [2:0] ARM   = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic             href_r1, href_r2;
  logic [PIX_W-1:0] data_r1, data_r2;
  logic             vsync_reg, vsync_prev;
  logic             kick_r1, kick_s;
  logic             frame_start;

  logic [2:0]        state_reg;
  logic [CNT_W-1:0]  pix_cnt;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] word_next;
  logic [ADDR_W:0]   next_addr;
  logic [ADDR_W:0]   next_addr_inc;
  logic [ADDR_W-1:0] wr_addr;
  logic              at_limit;
  logic              word_fire;
`ifdef PIXCAP_SRAM_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr;
`endif

  // Retime the sensor bus and synchronise the asynchronous kick level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      href_r1    <= 1'b0;
      href_r2    <= 1'b0;
      data_r1    <= '0;
      data_r2    <= '0;
      vsync_reg  <= 1'b0;
      vsync_prev <= 1'b0;
      kick_r1    <= 1'b0;
      kick_s     <= 1'b0;
    end else begin
      href_r1    <= HREF;
      href_r2    <= href_r1;
      data_r1    <= DATA;
      data_r2    <= data_r1;
      vsync_reg  <= VSYNC;
      vsync_prev <= vsync_reg;
      kick_r1    <= fetch_kick;
      kick_s     <= kick_r1;
    end
  end

  assign frame_start = vsync_reg & ~vsync_prev;

  // New pixel enters at the top so the first pixel of a word ends up in the LSBs
  generate
    if (PPW == 1) begin : g_single
      assign word_next = data_r2;
    end else begin : g_pack
      assign word_next = {data_r2, shift_reg[WORD_W-1:PIX_W]};
    end
  endgenerate

  // Once the frame is full, further words keep hitting the last slot
  assign at_limit      = (next_addr >= MAX_CNT);
  assign wr_addr       = at_limit ? SAT_ADDR : next_addr[ADDR_W-1:0];
  assign next_addr_inc = at_limit ? next_addr : next_addr + 1'b1;
  assign word_fire     = (state_reg == RUN) && href_r2 && (pix_cnt == CNT_LAST);

`ifdef PIXCAP_SRAM_CLEAR_EN
  assign busy = (state_reg == CLEAR) || (state_reg == ARM) || (state_reg == RUN);
`else
  assign busy = (state_reg == ARM) || (state_reg == RUN);
`endif

  // Capture FSM, packing and SRAM write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      pix_cnt    <= '0;
      shift_reg  <= '0;
      next_addr  <= '0;
      fetch_done <= 1'b0;
      s0_WE      <= 1'b1;
      s0_Addr    <= '1;
      s0_WD      <= '0;
      last_addr  <= '0;
      word_cnt   <= '0;
      overflow   <= 1'b0;
`ifdef PIXCAP_SRAM_CLEAR_EN
      clr_addr   <= '0;
`endif
    end else begin
      s0_WE <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (kick_s) begin
            overflow  <= 1'b0;
            next_addr <= '0;
`ifdef PIXCAP_SRAM_CLEAR_EN
            clr_addr  <= '0;
            state_reg <= CLEAR;
`else
            state_reg <= ARM;
`endif
          end
        end
`ifdef PIXCAP_SRAM_CLEAR_EN
        CLEAR: begin
          s0_WE    <= 1'b0;
          s0_Addr  <= clr_addr;
          s0_WD    <= FILL_WORD;
          clr_addr <= clr_addr + 1'b1;
          if (&clr_addr) state_reg <= ARM;
        end
`endif
        ARM: begin
          if (frame_start) begin
            state_reg <= RUN;
            next_addr <= '0;
            pix_cnt   <= '0;
          end
        end
        RUN: begin
          if (href_r2) shift_reg <= word_next;
          if (word_fire) begin
            s0_WE     <= 1'b0;
            s0_WD     <= word_next;
            s0_Addr   <= wr_addr;
            next_addr <= next_addr_inc;
            if (at_limit) overflow <= 1'b1;
          end
          // A word completing together with frame_start is still counted
          if (frame_start) begin
            state_reg  <= DONE;
            fetch_done <= 1'b1;
            pix_cnt    <= '0;
            last_addr  <= word_fire ? wr_addr : s0_Addr;
            word_cnt   <= word_fire ? next_addr_inc : next_addr;
          end else if (href_r2) begin
            pix_cnt <= (pix_cnt == CNT_LAST) ? '0 : pix_cnt + 1'b1;
          end
        end
        DONE: begin
          if (!kick_s) begin
            fetch_done <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
